// File: rtl/bt_cmd_ctrl.sv
// Remote-command decoder for the car audio path: maps ASCII command bytes to
// volume, song, mute and play state, rate-limited by a hold-off window.
module bt_cmd_ctrl #(
    parameter int VOL_W      = 2,
    parameter int VOL_MAX    = 3,
    parameter int VOL_INIT   = 3,
    parameter int SONG_W     = 4,
    parameter int SONG_COUNT = 8,
    parameter int SONG_INIT  = 1,
    parameter int HOLDOFF    = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [VOL_W-1:0]  vol,
    output logic [SONG_W-1:0] song,
    output logic              mute,
    output logic              playing,
    output logic              busy,
    output logic              cmd_ack,
    output logic              cmd_drop
);

    localparam int CNT_W = $clog2(HOLDOFF + 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLDOFF - 1);
    localparam logic [VOL_W:0]    VOL_TOP   = (VOL_W + 1)'(VOL_MAX);
    localparam logic [SONG_W:0]   SONG_LAST = (SONG_W + 1)'(SONG_COUNT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [VOL_W-1:0]  vol_next;
    logic [SONG_W-1:0] song_next;
    logic              mute_next, playing_next, ack_next, drop_next;
    logic              recognised;
    logic [VOL_W:0]    vol_ext;
    logic [SONG_W:0]   song_ext;

    assign recognised = rx_valid && (rx_data >= 8'h31) && (rx_data <= 8'h36);
    assign vol_ext    = {1'b0, vol};
    assign song_ext   = {1'b0, song};
    assign busy       = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            vol      <= VOL_W'(VOL_INIT);
            song     <= SONG_W'(SONG_INIT);
            mute     <= 1'b0;
            playing  <= 1'b1;
            cmd_ack  <= 1'b0;
            cmd_drop <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            vol      <= vol_next;
            song     <= song_next;
            mute     <= mute_next;
            playing  <= playing_next;
            cmd_ack  <= ack_next;
            cmd_drop <= drop_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        vol_next     = vol;
        song_next    = song;
        mute_next    = mute;
        playing_next = playing;
        ack_next     = 1'b0;
        drop_next    = 1'b0;
        case (state)
            IDLE: begin
                if (recognised) begin
                    ack_next   = 1'b1;
                    cnt_next   = HOLD_LOAD;
                    state_next = HOLD;
                    case (rx_data)
                        8'h31: if (vol_ext < VOL_TOP) vol_next = vol + VOL_W'(1);
                        8'h32: if (vol_ext != '0) vol_next = vol - VOL_W'(1);
                        8'h33: song_next = (song_ext == '0) ? SONG_LAST[SONG_W-1:0]
                                                            : song - SONG_W'(1);
                        8'h34: song_next = (song_ext >= SONG_LAST) ? '0
                                                                   : song + SONG_W'(1);
                        8'h35: mute_next = ~mute;
                        default: playing_next = ~playing;
                    endcase
                end
            end
            HOLD: begin
                // Commands arriving in hold-off, including on the final edge, are only reported.
                drop_next = recognised;
                if (cnt == '0) state_next = IDLE;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Directed self-checking bench for bt_cmd_ctrl with a short hold-off window.
module tb_bt_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [1:0] vol;
    logic [3:0] song;
    logic       mute, playing, busy, cmd_ack, cmd_drop;

    int n_checks = 0;
    int n_fail   = 0;

    bt_cmd_ctrl #(
        .VOL_W(2), .VOL_MAX(3), .VOL_INIT(3),
        .SONG_W(4), .SONG_COUNT(8), .SONG_INIT(1),
        .HOLDOFF(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .vol(vol), .song(song), .mute(mute), .playing(playing), .busy(busy),
        .cmd_ack(cmd_ack), .cmd_drop(cmd_drop)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents one byte for exactly one rising edge; returns at the negedge after it.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        n_checks++;
        if ({vol, song, mute, playing, busy, cmd_ack, cmd_drop} !== {2'd3, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_values: vol=%0d song=%0d mute=%b play=%b busy=%b ack=%b drop=%b, required 3 1 0 1 0 0 0",
                     vol, song, mute, playing, busy, cmd_ack, cmd_drop);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_vol_down;
        logic [1:0] exp_vol [4] = '{2'd2, 2'd1, 2'd0, 2'd0};
        int busy_cycles;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h32);
            n_checks++;
            if (vol !== exp_vol[i] || cmd_ack !== 1'b1 || cmd_drop !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL vol_down_%0d: vol=%0d ack=%b drop=%b busy=%b, required vol=%0d ack=1 drop=0 busy=1",
                         i, vol, cmd_ack, cmd_drop, busy, exp_vol[i]);
            end
            if (i < 3) idle(5);
        end
        busy_cycles = 1;
        @(negedge clk);
        n_checks++;
        if (cmd_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ack_width: ack=%b, required 0", cmd_ack);
        end
        if (busy) busy_cycles++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        n_checks++;
        if (busy_cycles !== 4) begin
            n_fail++;
            $display("[TB] FAIL busy_length: %0d cycles, required 4", busy_cycles);
        end
    endtask

    task automatic test_song_wrap;
        logic [7:0] cmds [3]     = '{8'h33, 8'h33, 8'h34};
        logic [3:0] exp_song [3] = '{4'd0, 4'd7, 4'd0};
        for (int i = 0; i < 3; i++) begin
            send_byte(cmds[i]);
            n_checks++;
            if (song !== exp_song[i] || cmd_ack !== 1'b1 || playing !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL song_%0d: song=%0d ack=%b play=%b, required song=%0d ack=1 play=1",
                         i, song, cmd_ack, playing, exp_song[i]);
            end
            idle(5);
        end
    endtask

    task automatic test_holdoff_drop;
        logic [5:0] pat      = 6'b110101;
        logic [5:0] exp_ack  = 6'b100001;
        logic [5:0] exp_drop = 6'b010100;
        logic [1:0] exp_vol;
        rx_data = 8'h31;
        for (int k = 0; k < 6; k++) begin
            rx_valid = pat[k];
            @(negedge clk);
            exp_vol = (k == 5) ? 2'd2 : 2'd1;
            n_checks++;
            if (cmd_ack !== exp_ack[k] || cmd_drop !== exp_drop[k] || vol !== exp_vol) begin
                n_fail++;
                $display("[TB] FAIL holdoff_E%0d: ack=%b drop=%b vol=%0d, required ack=%b drop=%b vol=%0d",
                         k, cmd_ack, cmd_drop, vol, exp_ack[k], exp_drop[k], exp_vol);
            end
        end
        rx_valid = 1'b0;
        idle(5);
    endtask

    task automatic test_mute_play;
        logic [7:0] junk [3] = '{8'h30, 8'h37, 8'h41};
        send_byte(8'h35);
        n_checks++;
        if (mute !== 1'b1 || playing !== 1'b1 || vol !== 2'd2 || cmd_ack !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mute_toggle: mute=%b play=%b vol=%0d ack=%b, required 1 1 2 1", mute, playing, vol, cmd_ack);
        end
        idle(5);
        send_byte(8'h36);
        n_checks++;
        if (mute !== 1'b1 || playing !== 1'b0 || song !== 4'd0 || cmd_ack !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL play_toggle: mute=%b play=%b song=%0d ack=%b, required 1 0 0 1", mute, playing, song, cmd_ack);
        end
        idle(5);
        for (int i = 0; i < 3; i++) begin
            send_byte(junk[i]);
            n_checks++;
            if ({cmd_ack, cmd_drop, busy, vol, song, mute, playing} !== {1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL ignore_%0h: ack=%b drop=%b busy=%b vol=%0d song=%0d mute=%b play=%b, required 0 0 0 2 0 1 0",
                         junk[i], cmd_ack, cmd_drop, busy, vol, song, mute, playing);
            end
        end
    endtask

    task automatic test_reset_mid_hold;
        send_byte(8'h34);
        n_checks++;
        if (song !== 4'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_accept: song=%0d busy=%b, required 1 1", song, busy);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vol, song, mute, playing, busy, cmd_ack, cmd_drop} !== {2'd3, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL async_reset: vol=%0d song=%0d mute=%b play=%b busy=%b ack=%b drop=%b, required 3 1 0 1 0 0 0",
                     vol, song, mute, playing, busy, cmd_ack, cmd_drop);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        rx_data  = 8'h34;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        n_checks++;
        if (song !== 4'd2 || cmd_ack !== 1'b1 || cmd_drop !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_accept: song=%0d ack=%b drop=%b, required 2 1 0", song, cmd_ack, cmd_drop);
        end
        idle(5);
    endtask

    task automatic test_back_to_back;
        int acks = 0;
        int drops = 0;
        rx_data  = 8'h31;
        rx_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (cmd_ack) acks++;
            if (cmd_drop) drops++;
            n_checks++;
            if ((cmd_ack & cmd_drop) !== 1'b0 || cmd_ack !== (k == 0 || k == 5) || vol !== 2'd3) begin
                n_fail++;
                $display("[TB] FAIL b2b_E%0d: ack=%b drop=%b vol=%0d, required ack=%b drop=%b vol=3",
                         k, cmd_ack, cmd_drop, vol, (k == 0 || k == 5), !(k == 0 || k == 5));
            end
        end
        rx_valid = 1'b0;
        n_checks++;
        if (acks !== 2 || drops !== 4) begin
            n_fail++;
            $display("[TB] FAIL b2b_totals: acks=%0d drops=%0d, required 2 4", acks, drops);
        end
        @(negedge clk);
        n_checks++;
        if (cmd_ack !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_tail: ack=%b busy=%b, required 0 1", cmd_ack, busy);
        end
    endtask

    initial begin
        test_reset();
        test_vol_down();
        test_song_wrap();
        test_holdoff_drop();
        test_mute_play();
        test_reset_mid_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
